pop_stack_controller: RTL and testbench
=======================================

POP_STACK_CONTROLLER -- requirements
Module: pop_stack_controller

Interface
REQ-001 Parameter WIDTH, default 3, entry width in bits.
REQ-002 Parameter DEPTH, default 8, maximum number of stored entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 push_valid  input  1  write request for push_data.
REQ-006 push_data  input  WIDTH  entry to push.
REQ-007 push_ready  output  1  combinational: high when (state==IDLE) and not full.
REQ-008 pop_req  input  1  request to remove the top entry.
REQ-009 pop_valid  output  1  registered one-cycle pulse; pop_data is valid while it is high.
REQ-010 pop_data  output  WIDTH  registered popped entry; holds its last value otherwise.
REQ-011 dump_req  input  1  request to drain the whole stack, top first.
REQ-012 dump_valid  output  1  registered; high for each cycle in which dump_data carries an entry.
REQ-013 dump_data  output  WIDTH  registered drained entry.
REQ-014 dump_done  output  1  registered one-cycle pulse at the end of a dump.
REQ-015 count  output  log2(DEPTH)+1  current occupancy.
REQ-016 full, empty  output  1 each  combinational: count==DEPTH and count==0.
REQ-017 err_overflow, err_underflow  output  1 each  sticky error flags.

Function
REQ-018 The block SHALL hold entries in a register array indexed by count; the top entry is at index count-1.
REQ-019 The state machine SHALL have two states: IDLE and DUMP.
REQ-020 In IDLE, push accepted = push_valid && push_ready; the block writes push_data at index count and increments count.
REQ-021 In IDLE, pop accepted = pop_req && !empty; next cycle pop_data = top entry, pop_valid = 1, and count decrements.
REQ-022 Pop and push accepted in the same cycle (not full, not empty): pop_data = old top, push_data replaces the top slot, and count is unchanged.
REQ-023 Push while full (push_valid=1, full=1, IDLE): the block SHALL drop the push, set err_overflow, and leave the stack unchanged; a same-cycle pop still proceeds.
REQ-024 Pop while empty in IDLE: no pop_valid, set err_underflow; a same-cycle push is still accepted.
REQ-025 dump_req in IDLE with !empty: the block SHALL enter DUMP next cycle; dump_req has priority over push and pop in that cycle, and those requests are ignored.
REQ-026 In DUMP, each cycle the block SHALL output the top entry with dump_valid=1 and decrement count.
REQ-027 When the last entry is output (count becomes 0): dump_done=1 in that same cycle, and the state returns to IDLE.
REQ-028 Latency of a dump of N entries: N cycles of dump_valid, first one cycle after dump_req.
REQ-029 dump_req in IDLE with empty: dump_done pulses next cycle, no dump_valid, state stays IDLE.
REQ-030 In DUMP, push_ready=0; push_valid, pop_req and dump_req are ignored and SHALL NOT set error flags.
REQ-031 Error flags clear only on rst.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, count=0, and pop_valid, dump_valid, dump_done, err_overflow and err_underflow = 0.
REQ-033 On the same reset edge, pop_data and dump_data = 0 and all array entries = 0.
REQ-034 Reset mid-DUMP SHALL abort the dump immediately, with no dump_done pulse.
REQ-035 Reset has priority over every other input.

Verification
REQ-036 Push 3,5,7 on consecutive cycles, then pop three times -> pop_data 7,5,3 on successive pop_valid pulses; count 3->0; empty=1.
REQ-037 Push 8 entries (0..7), then push 6 -> full=1, push_ready=0, err_overflow=1, count=8; top still 7.
REQ-038 Stack holding 2,4, then push 6 and pop in the same cycle -> pop_data=4, count=2, next pop returns 6.
REQ-039 Stack holding 1,2,3, then dump_req -> dump_data 3,2,1 on three consecutive cycles; dump_done with the third; count=0; a push_valid during the dump is ignored.
REQ-040 Pop on empty stack -> err_underflow=1, no pop_valid; dump_req on empty -> dump_done only.
REQ-041 Assert rst during the second dump cycle -> next cycle count=0, dump_valid=0, dump_done never pulses, state IDLE.

Source files
------------

// File: rtl/pop_stack_controller.sv
// LIFO stack with single-entry pop, whole-stack drain (dump), and sticky
// overflow/underflow flags. Entries live in a register array indexed by count.
module pop_stack_controller #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     push_ready,
  input  logic                     pop_req,
  output logic                     pop_valid,
  output logic [WIDTH-1:0]         pop_data,
  input  logic                     dump_req,
  output logic                     dump_valid,
  output logic [WIDTH-1:0]         dump_data,
  output logic                     dump_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     err_overflow,
  output logic                     err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, DUMP} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             push_acc;
  logic             pop_acc;
  logic             last_entry;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign push_ready = (state == IDLE) && !full;
  assign top_idx    = count[AW-1:0] - AW'(1);
  assign wr_idx     = count[AW-1:0];
  assign push_acc   = push_valid && push_ready;
  assign pop_acc    = pop_req && !empty;
  assign last_entry = (count == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      pop_valid     <= 1'b0;
      pop_data      <= '0;
      dump_valid    <= 1'b0;
      dump_data     <= '0;
      dump_done     <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      pop_valid  <= 1'b0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_req) begin
            // The first drained entry is emitted on the accepting edge so the
            // dump_valid burst starts one cycle after the request.
            if (empty) begin
              dump_done <= 1'b1;
            end else begin
              dump_valid <= 1'b1;
              dump_data  <= mem[top_idx];
              count      <= count - CW'(1);
              if (last_entry) dump_done <= 1'b1;
              else            state     <= DUMP;
            end
          end else begin
            if (push_valid && full) err_overflow  <= 1'b1;
            if (pop_req && empty)   err_underflow <= 1'b1;
            if (pop_acc) begin
              pop_valid <= 1'b1;
              pop_data  <= mem[top_idx];
            end
            if (push_acc && pop_acc) begin
              mem[top_idx] <= push_data;
            end else if (push_acc) begin
              mem[wr_idx] <= push_data;
              count       <= count + CW'(1);
            end else if (pop_acc) begin
              count <= count - CW'(1);
            end
          end
        end
        DUMP: begin
          dump_valid <= 1'b1;
          dump_data  <= mem[top_idx];
          count      <= count - CW'(1);
          if (last_entry) begin
            dump_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pop_stack_controller.sv
// Directed and randomized checks of pop_stack_controller against a queue-based
// behavioural model of the stack.
module tb_pop_stack_controller;

  localparam int WIDTH = 3;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             push_valid;
  logic [WIDTH-1:0] push_data;
  logic             push_ready;
  logic             pop_req;
  logic             pop_valid;
  logic [WIDTH-1:0] pop_data;
  logic             dump_req;
  logic             dump_valid;
  logic [WIDTH-1:0] dump_data;
  logic             dump_done;
  logic [3:0]       count;
  logic             full;
  logic             empty;
  logic             err_overflow;
  logic             err_underflow;

  int checks   = 0;
  int failures = 0;

  pop_stack_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_data(dump_data),
    .dump_done(dump_done), .count(count), .full(full), .empty(empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: the stack is a queue, top at the back.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_pd, m_dd;
  bit m_pv, m_dv, m_dn, m_ovf, m_unf, m_dumping, m_init;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit pv, input logic [WIDTH-1:0] d,
                            input bit pp, input bit dr);
    bit was_full;
    m_pv = 0; m_dv = 0; m_dn = 0;
    if (r) begin
      q.delete();
      m_pd = '0; m_dd = '0; m_ovf = 0; m_unf = 0; m_dumping = 0;
    end else if (m_dumping) begin
      m_dv = 1; m_dd = q.pop_back();
      if (q.size() == 0) begin m_dn = 1; m_dumping = 0; end
    end else if (dr) begin
      if (q.size() == 0) m_dn = 1;
      else begin
        m_dv = 1; m_dd = q.pop_back();
        if (q.size() == 0) m_dn = 1; else m_dumping = 1;
      end
    end else begin
      was_full = (q.size() == DEPTH);
      if (pv && was_full) m_ovf = 1;
      if (pp && q.size() == 0) m_unf = 1;
      if (pp && q.size() > 0) begin m_pv = 1; m_pd = q.pop_back(); end
      if (pv && !was_full) q.push_back(d);
    end
  endtask

  task automatic step(input bit r, input bit pv, input logic [WIDTH-1:0] d,
                      input bit pp, input bit dr);
    rst = r; push_valid = pv; push_data = d; pop_req = pp; dump_req = dr;
    #1;
    if (m_init) begin
      chk("count_pre", count, q.size());
      chk("empty", empty, q.size() == 0);
      chk("full", full, q.size() == DEPTH);
      chk("push_ready", push_ready, !m_dumping && q.size() < DEPTH);
    end
    @(posedge clk);
    model_edge(r, pv, d, pp, dr);
    m_init = 1;
    #1;
    chk("pop_valid", pop_valid, m_pv);
    chk("pop_data", pop_data, m_pd);
    chk("dump_valid", dump_valid, m_dv);
    chk("dump_data", dump_data, m_dd);
    chk("dump_done", dump_done, m_dn);
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_underflow", err_underflow, m_unf);
    chk("count", count, q.size());
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0);
  endtask

  initial begin
    m_init = 0;
    rst = 1; push_valid = 0; push_data = '0; pop_req = 0; dump_req = 0;
    @(posedge clk); #1;
    step(1, 0, '0, 0, 0);
    chk("reset_empty", empty, 1);

    // Push 3,5,7 then pop three times.
    step(0, 1, 3'd3, 0, 0);
    step(0, 1, 3'd5, 0, 0);
    step(0, 1, 3'd7, 0, 0);
    chk("lifo_count3", count, 3);
    step(0, 0, '0, 1, 0); chk("lifo_pop7", pop_data, 7);
    step(0, 0, '0, 1, 0); chk("lifo_pop5", pop_data, 5);
    step(0, 0, '0, 1, 0); chk("lifo_pop3", pop_data, 3);
    chk("lifo_empty", empty, 1);

    // Fill, then overflow; top must still be 7.
    for (int i = 0; i < DEPTH; i++) step(0, 1, WIDTH'(i), 0, 0);
    step(0, 1, 3'd6, 0, 0);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_ready", push_ready, 0);
    chk("ovf_count", count, 8);
    step(0, 1, 3'd6, 1, 0);
    chk("ovf_top7", pop_data, 7);
    chk("ovf_count7", count, 7);

    // Same-cycle push and pop on a stack holding 2,4.
    step(1, 0, '0, 0, 0);
    step(0, 1, 3'd2, 0, 0);
    step(0, 1, 3'd4, 0, 0);
    step(0, 1, 3'd6, 1, 0);
    chk("swap_pop4", pop_data, 4);
    chk("swap_count2", count, 2);
    step(0, 0, '0, 1, 0);
    chk("swap_pop6", pop_data, 6);
    step(0, 0, '0, 1, 0);

    // Dump of 1,2,3 with a push attempted mid-dump.
    step(0, 1, 3'd1, 0, 0);
    step(0, 1, 3'd2, 0, 0);
    step(0, 1, 3'd3, 0, 0);
    step(0, 0, '0, 0, 1); chk("dump_d3", dump_data, 3);
    step(0, 1, 3'd5, 1, 0); chk("dump_d2", dump_data, 2);
    step(0, 0, '0, 0, 0); chk("dump_d1", dump_data, 1);
    chk("dump_done3", dump_done, 1);
    chk("dump_cnt0", count, 0);
    idle();

    // Underflow on empty, then dump on empty.
    step(0, 0, '0, 1, 0);
    chk("unf_flag", err_underflow, 1);
    step(0, 0, '0, 0, 1);
    chk("dump_empty_done", dump_done, 1);
    chk("dump_empty_valid", dump_valid, 0);
    idle();

    // Reset during the second dump cycle.
    step(0, 1, 3'd1, 0, 0);
    step(0, 1, 3'd2, 0, 0);
    step(0, 1, 3'd3, 0, 0);
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    chk("abort_count", count, 0);
    chk("abort_dvalid", dump_valid, 0);
    chk("abort_done", dump_done, 0);
    idle();
    idle();
    chk("abort_ready", push_ready, 1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) < 6,
           WIDTH'($urandom),
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 24) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

endmodule
